// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared defaults and types for the LLR message BRAM arbiter.
package bram_arb_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
    typedef logic req_id_t;
endpackage

// File: rtl/bram_arb_rd_tag.sv
// bram_arb_rd_tag: (valid, owner) tag pipeline that steers read-valid back to the issuing requester.
module bram_arb_rd_tag
    import bram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
)(
    input  logic    clk,
    input  logic    reset,
    input  logic    issue,
    input  req_id_t owner,
    output logic    rvalid0,
    output logic    rvalid1
);
    logic [RD_LAT:0] vld;
    logic [RD_LAT:0] own;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            own <= '0;
        end else begin
            vld <= {vld[RD_LAT-1:0], issue};
            own <= {own[RD_LAT-1:0], owner};
        end
    end

    assign rvalid0 = vld[RD_LAT] & ~own[RD_LAT];
    assign rvalid1 = vld[RD_LAT] & own[RD_LAT];
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester round-robin arbiter for the shared LLR message BRAM.
// Define BRAM_ARB_LOCK_EN to enable locked multi-access sequences.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data_in,
    output logic              bram_write,
    input  logic [DATA_W-1:0] bram_data_out
);
    state_t  state;
    req_id_t ptr;
    req_id_t id;
    logic    accept;
    logic    we_g;
    logic    lock_g;

    always_comb begin
        gnt0 = (state == LOCK0) ? req0 : (state == ARB) && req0 && (!req1 || ptr == 1'b0);
        gnt1 = (state == LOCK1) ? req1 : (state == ARB) && req1 && (!req0 || ptr == 1'b1);
    end

    assign accept = gnt0 | gnt1;
    assign id     = gnt1;
    assign we_g   = id ? we1 : we0;
    assign lock_g = id ? lock1 : lock0;
    assign rdata  = bram_data_out;

`ifdef BRAM_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    assign cnt_nxt = cnt + CW'(1);
`else
    logic unused_lock;
    assign unused_lock = lock_g ^ (MAX_LOCK == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ARB;
            ptr          <= 1'b0;
            bram_addr    <= '0;
            bram_data_in <= '0;
            bram_write   <= 1'b0;
`ifdef BRAM_ARB_LOCK_EN
            cnt          <= '0;
`endif
        end else begin
            if (accept) begin
                bram_addr    <= id ? addr1 : addr0;
                bram_data_in <= id ? wdata1 : wdata0;
            end
            bram_write <= accept & we_g;
`ifdef BRAM_ARB_LOCK_EN
            if (state == ARB) begin
                if (accept && lock_g && MAX_LOCK > 1) begin
                    state <= id ? LOCK1 : LOCK0;
                    cnt   <= CW'(1);
                end else if (accept) begin
                    ptr <= ~id;
                end
            // in a lock state a missing grant means the owner dropped its request
            end else if (!accept || !lock_g || cnt_nxt == CW'(MAX_LOCK)) begin
                state <= ARB;
                ptr   <= (state == LOCK0);
            end else begin
                cnt <= cnt_nxt;
            end
`else
            if (accept)
                ptr <= ~id;
`endif
        end
    end

    bram_arb_rd_tag #(.RD_LAT(RD_LAT)) u_rd_tag (
        .clk     (clk),
        .reset   (reset),
        .issue   (accept & ~we_g),
        .owner   (id),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1)
    );
endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester round-robin arbiter for the shared 16x8 LLR message BRAM of the LDPC decoder.
- Typical requesters: the check-node unit on port 0 and the variable-node unit on port 1.
- Serialises at most one read or write per cycle onto the single BRAM address/data/write port.
- Routes read-valid back to the issuing requester, and optionally supports locked read-modify-write sequences.

Parameters:
DATA_W, 8, BRAM word width
ADDR_W, 4, BRAM address width (16 words)
RD_LAT, 1, BRAM read latency in cycles from registered address to valid data_out (1..4)
MAX_LOCK, 4, max consecutive grants to one requester while locked (used only with lock feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0 / req1  in  1  access request; held stable until granted
we0 / we1  in  1  1 = write, 0 = read; qualified by req
addr0 / addr1  in  ADDR_W  access address
wdata0 / wdata1  in  DATA_W  write data
lock0 / lock1  in  1  hold grant for follow-on accesses (ignored unless feature enabled)
gnt0 / gnt1  out  1  combinational grant; access accepted in a cycle where req&gnt
rvalid0 / rvalid1  out  1  read data valid for that requester
rdata  out  DATA_W  read data, common to both requesters (driven from bram_data_out)
bram_addr  out  ADDR_W  registered BRAM address
bram_data_in  out  DATA_W  registered BRAM write data
bram_write  out  1  registered BRAM write enable
bram_data_out  in  DATA_W  BRAM read data

Behaviour:
- Reset values:
  - gnt0/1=0, rvalid0/1=0, bram_write=0, bram_addr=0, bram_data_in=0.
  - Round-robin pointer=0 (requester 0 favoured); lock counter=0; state=ARB.
- Reset mid-operation clears the rvalid tag pipeline; no rvalid is ever produced for an access granted before reset.
- gnt is a function of req, pointer and state only. It never depends on gnt (no loops). gnt0 and gnt1 are mutually exclusive.
- Arbitration in state ARB:
  - Single req: granted.
  - Both req: the requester named by the pointer wins.
  - After any unlocked grant, the pointer moves to the other requester.
- Grant cycle t: bram_addr, bram_data_in and bram_write (=we) are registered at the end of t and are visible in t+1. bram_write is a one-cycle pulse per write grant; it is 0 for reads and idle cycles.
- Read return: rvalid_x=1 in cycle t+1+RD_LAT exactly, for exactly one cycle. rdata = bram_data_out in that cycle.
- Back-to-back reads are fully pipelined at one per cycle; rvalid ordering equals grant ordering.
- Write then read, same address, consecutive grants (either requester): the read returns the new data, because BRAM accesses occur in separate cycles.
- Idle cycles (no req): BRAM outputs hold their last addr/data, and bram_write=0.
- States: ARB, LOCK0, LOCK1 (reachable only with the lock feature).

Optional Feature:
BRAM_ARB_LOCK_EN
- Defined:
  - A grant to x with lock_x=1 moves the arbiter to LOCKx and loads the lock counter with 1.
  - In LOCKx only requester x can be granted; the other sees gnt=0. Each grant increments the counter.
  - Return to ARB with the pointer set to the other requester when any of these holds: lock_x=0 on a grant; req_x=0 for a cycle; the counter reaches MAX_LOCK on a grant.
- Undefined: lock0/lock1 are ignored, LOCK states are absent, and behaviour is pure round-robin.

Decomposition:
- Package bram_arb_pkg: DATA_W/ADDR_W defaults, state enum (ARB, LOCK0, LOCK1), requester-id type (1 bit).
- Sub-module bram_arb_rd_tag: (valid, owner) shift register of depth RD_LAT+1, cleared by reset, producing rvalid0/rvalid1.

Test Plan:
- Reset held 100 ns, then released -> all outputs 0. First req1 only (read, addr 1) granted in cycle t; bram_addr=1 at t+1; rvalid1 at t+2 (RD_LAT=1).
- req0 and req1 both held high for 4 cycles (reads, addr 2 and 3) -> grants alternate 0,1,0,1 and rvalids alternate in the same order, 2 cycles later.
- req0 writes 0xA5 to addr 3, then req1 reads addr 3 -> bram_write pulses once, then rvalid1 with rdata=0xA5.
- reset asserted while 2 reads are in flight -> no rvalid in the following cycles; the pointer returns to 0.
- With BRAM_ARB_LOCK_EN: req0 and lock0 held high for 6 cycles, req1 held high -> gnt0 for 4 cycles (MAX_LOCK), then gnt1 for 1 cycle.
- Without BRAM_ARB_LOCK_EN, same stimulus -> strict alternation.
